imem_bank_server: RTL and testbench

Instruction-memory responder for the fetch FIFO. It answers halfword-aligned 32-bit fetch requests in one cycle, so a 32-bit instruction that straddles a word boundary (after a compressed instruction) returns whole. It also owns the program-image load port used by the bench and boot loader. It sits between the fetch FIFO's request outputs (address and request strobe) and its memory-data input, replacing the single-bank SRAM wrapper.

---
 rtl/imem_bank_server.sv | 116 +++++++++++
 tb/tb_imem_bank_server.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/imem_bank_server.sv
// imem_bank_server: two-bank halfword instruction memory with 1-cycle straddling fetch and a load port.
// Optional parity protection is enabled by defining IMEM_PARITY_EN.
module imem_bank_server #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH_HW  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic [31:0] fetch_data_o,
    output logic        fetch_valid_o,
    output logic        fetch_oor_o,
    input  logic        load_valid_i,
    output logic        load_ready_o,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    input  logic        load_done_i,
`ifdef IMEM_PARITY_EN
    output logic        parity_err_o,
`endif
    output logic        run_o
);
    localparam int          HW   = $clog2(DEPTH_HW);
    localparam int          BW   = HW - 1;
    localparam int          NB   = DEPTH_HW / 2;
    localparam logic [31:0] SPAN = 32'(2 * DEPTH_HW);
    localparam logic [31:0] NOP  = 32'h0000_0013;
`ifdef IMEM_PARITY_EN
    localparam int EW = 17;
    function automatic logic [EW-1:0] enc(input logic [15:0] d);
        return {^d, d};
    endfunction
`else
    localparam int EW = 16;
    function automatic logic [EW-1:0] enc(input logic [15:0] d);
        return d;
    endfunction
`endif

    typedef enum logic {LOAD, RUN} state_e;

    state_e          state_q;
    logic [EW-1:0]   even_q [NB];
    logic [EW-1:0]   odd_q  [NB];
    logic [31:0]     data_q, data_d;
    logic            valid_q, oor_q;
    logic [31:0]     foff, loff;
    logic            f_in, l_in, serve, wr_en;
    logic [HW-1:0]   fh;
    logic [BW-1:0]   lo_idx, hi_idx, lw;
    logic [EW-1:0]   lo_e, hi_e;
    logic            unused_bits;

    assign unused_bits = &{1'b0, foff[0], loff[1:0]};

    // Address decode and straddling read across the two banks
    always_comb begin
        foff   = fetch_addr_i - BASE_ADDR;
        loff   = load_addr_i - BASE_ADDR;
        f_in   = foff < SPAN;
        l_in   = loff < SPAN;
        fh     = foff[HW:1];
        lw     = loff[HW:2];
        lo_idx = fh[HW-1:1];
        hi_idx = fh[0] ? lo_idx + BW'(1) : lo_idx;
        lo_e   = fh[0] ? odd_q[lo_idx] : even_q[lo_idx];
        hi_e   = fh[0] ? even_q[hi_idx] : odd_q[hi_idx];
        data_d = f_in ? {hi_e[15:0], lo_e[15:0]} : NOP;
        serve  = (state_q == RUN) && fetch_req_i;
        wr_en  = (state_q == LOAD) && load_valid_i && l_in && !rst;
    end

    // Bank storage: never reset so an image survives a reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            even_q[lw] <= enc(load_data_i[15:0]);
            odd_q[lw]  <= enc(load_data_i[31:16]);
        end
    end

    // Mode FSM with registered fetch response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            data_q  <= '0;
            valid_q <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            if (state_q == LOAD && load_done_i)
                state_q <= RUN;
            valid_q <= serve;
            oor_q   <= serve && !f_in;
            if (serve)
                data_q <= data_d;
        end
    end

`ifdef IMEM_PARITY_EN
    logic perr_q;
    // Sticky parity error raised by any in-range fetch touching a corrupted entry
    always_ff @(posedge clk) begin
        if (rst)
            perr_q <= 1'b0;
        else if (serve && f_in && ((^lo_e) || (^hi_e)))
            perr_q <= 1'b1;
    end
    assign parity_err_o = perr_q;
`endif

    assign fetch_data_o  = data_q;
    assign fetch_valid_o = valid_q;
    assign fetch_oor_o   = oor_q;
    assign load_ready_o  = (state_q == LOAD);
    assign run_o         = (state_q == RUN);
endmodule

// File: tb/tb_imem_bank_server.sv
// tb_imem_bank_server: directed stimulus checked against a halfword-array model plus literal expectations.
module tb_imem_bank_server;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          D    = 1024;

    logic        clk = 0, rst = 1;
    logic        fetch_req = 0, load_valid = 0, load_done = 0;
    logic [31:0] fetch_addr = 0, load_addr = 0, load_data = 0;
    logic [31:0] fetch_data_o;
    logic        fetch_valid_o, fetch_oor_o, load_ready_o, run_o;
`ifdef IMEM_PARITY_EN
    logic        parity_err_o;
`endif
    int checks = 0, errors = 0;

    imem_bank_server #(.BASE_ADDR(BASE), .DEPTH_HW(D)) dut (
        .clk(clk), .rst(rst),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
        .fetch_data_o(fetch_data_o), .fetch_valid_o(fetch_valid_o), .fetch_oor_o(fetch_oor_o),
        .load_valid_i(load_valid), .load_ready_o(load_ready_o),
        .load_addr_i(load_addr), .load_data_i(load_data), .load_done_i(load_done),
`ifdef IMEM_PARITY_EN
        .parity_err_o(parity_err_o),
`endif
        .run_o(run_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Model: flat halfword array, mode flag, expected response
    logic [15:0] mem [D];
    bit          started = 0, m_run = 0, e_valid = 0, e_oor = 0;
    logic [31:0] e_data = 0;
    int          mw, mh;

    function automatic bit in_rng(input logic [31:0] a);
        logic [63:0] a64 = {32'h0, a};
        return a64 >= 64'(BASE) && a64 < 64'(BASE) + 64'(2 * D);
    endfunction

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            m_run = 0; e_valid = 0; e_oor = 0; e_data = 0;
        end else begin
            if (!m_run && load_valid && in_rng(load_addr)) begin
                mw = int'((load_addr - BASE) >> 2);
                mem[2*mw]   = load_data[15:0];
                mem[2*mw+1] = load_data[31:16];
            end
            e_valid = m_run && fetch_req;
            e_oor = 0;
            if (e_valid) begin
                if (in_rng(fetch_addr)) begin
                    mh = int'((fetch_addr - BASE) >> 1);
                    e_data = {mem[(mh+1)%D], mem[mh]};
                end else begin
                    e_data = 32'h0000_0013;
                    e_oor = 1;
                end
            end
            if (!m_run && load_done) m_run = 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_valid", fetch_valid_o, e_valid);
            check("m_run", run_o, m_run);
            check("m_ready", load_ready_o, !m_run);
            check("m_data", fetch_data_o, e_data);
            if (e_valid) check("m_oor", fetch_oor_o, e_oor);
        end
    end

    task automatic do_fetch(input logic [31:0] a);
        fetch_req = 1; fetch_addr = a;
        @(negedge clk);
        fetch_req = 0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic done);
        load_valid = 1; load_addr = a; load_data = d; load_done = done;
        @(negedge clk);
        load_valid = 0; load_done = 0;
    endtask

    logic [31:0] b2b_addr [4] = '{BASE, BASE + 2, BASE + 4, BASE + 6};
    logic [31:0] b2b_exp  [4] = '{32'h1111_0000, 32'h2222_1111, 32'h3333_2222, 32'h4444_3333};

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_run", run_o, 0);
        check("rst_ready", load_ready_o, 1);
        check("rst_valid", fetch_valid_o, 0);
        check("rst_data", fetch_data_o, 0);
        do_fetch(BASE);
        check("fetch_in_load", fetch_valid_o, 0);
        do_load(BASE, 32'h1111_0000, 0);
        do_load(BASE + 4, 32'h3333_2222, 0);
        do_load(BASE + 8, 32'h5555_4444, 0);
        do_load(BASE + 32'h800, 32'hDEAD_BEEF, 0);
        check("ready_load", load_ready_o, 1);
        do_load(BASE + 32'h7FC, 32'hBEEF_0000, 1);
        check("run_rise", run_o, 1);
        do_fetch(BASE);
        check("aligned", fetch_data_o, 32'h1111_0000);
        check("aligned_v", fetch_valid_o, 1);
        do_fetch(BASE + 2);
        check("straddle", fetch_data_o, 32'h2222_1111);
        do_fetch(BASE + 3);
        check("bit0", fetch_data_o, 32'h2222_1111);
        do_fetch(BASE + 32'h7FE);
        check("wrap1", fetch_data_o, 32'h0000_BEEF);
        do_fetch(BASE + 32'h800);
        check("oor_data", fetch_data_o, 32'h0000_0013);
        check("oor_flag", fetch_oor_o, 1);
        do_fetch(BASE - 2);
        check("below_flag", fetch_oor_o, 1);
        load_valid = 1; load_addr = BASE; load_data = 32'hFFFF_FFFF;
        check("ready_run", load_ready_o, 0);
        @(negedge clk);
        load_valid = 0;
        do_fetch(BASE);
        check("run_write_drop", fetch_data_o, 32'h1111_0000);
        fetch_req = 1;
        for (int i = 0; i < 4; i++) begin
            fetch_addr = b2b_addr[i];
            @(negedge clk);
            check("b2b_v", fetch_valid_o, 1);
            check("b2b_d", fetch_data_o, b2b_exp[i]);
        end
        fetch_addr = BASE;
        @(negedge clk);
        fetch_addr = BASE + 2;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("mid_rst_v", fetch_valid_o, 0);
        check("mid_rst_run", run_o, 0);
        rst = 0;
        fetch_req = 0;
        do_load(BASE, 32'h0000_CAFE, 1);
        do_fetch(BASE + 32'h7FE);
        check("wrap2", fetch_data_o, 32'hCAFE_BEEF);
        do_fetch(BASE + 4);
        check("old_image", fetch_data_o, 32'h3333_2222);
`ifdef IMEM_PARITY_EN
        check("perr_clear", parity_err_o, 0);
        dut.even_q[0][16] = ~dut.even_q[0][16];
        do_fetch(BASE);
        check("perr_set", parity_err_o, 1);
        repeat (3) @(negedge clk);
        check("perr_sticky", parity_err_o, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("perr_rst", parity_err_o, 0);
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
